// File: rtl/comparator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : comparator_pkg
//  Purpose  : Shared types for the serial wide-operand comparator. Holds the
//             accumulator FSM state encoding, the result record reported to
//             the consumer, and the running-decision record plus the helper
//             that folds one 2-bit slice verdict into it.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Result presented to the consumer: A>B, A<B, A==B, malformed.
    typedef struct packed {
        logic g;
        logic l;
        logic eq;
        logic err;
    } result_t;

    // Running decision while slices stream in. 'fixed' marks that a
    // significant slice has already settled the outcome.
    typedef struct packed {
        logic fixed;
        logic g;
        logic l;
        logic err;
    } decision_t;

    localparam decision_t C_DEC_CLEAR = '0;

    // Fold one slice verdict into the running decision. Slices arrive MSB
    // first, so the first slice that differs decides the outcome. A slice
    // claiming both greater and less is contradictory: it is flagged and
    // otherwise ignored, so it cannot settle an undecided comparison.
    function automatic decision_t slice_fold(input decision_t d,
                                             input logic      sg,
                                             input logic      sl);
        decision_t r;
        r = d;
        if (sg && sl) begin
            r.err = 1'b1;
        end else if (!d.fixed && (sg || sl)) begin
            r.fixed = 1'b1;
            r.g     = sg;
            r.l     = sl;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/comparator_serial_accum.sv
`default_nettype none
// ============================================================================
//  Module   : comparator_serial_accum
//  Purpose  : Accumulates a stream of per-slice greater/less flags, most
//             significant slice first, into one wide-operand comparison
//             result with framing-error detection.
//  Ports    : clk        - clock, rising edge
//             rst_n      - synchronous active-low reset
//             in_valid   - slice beat present
//             in_ready   - beat accepted this cycle when in_valid is high
//             in_first   - beat is the MS slice (starts a transaction)
//             in_last    - beat is the LS slice (ends a transaction)
//             g, l       - slice verdict from the upstream 2-bit comparator
//             out_valid  - result present
//             out_ready  - consumer takes the result
//             out_g/out_l/out_eq - A>B / A<B / A==B
//             out_err    - transaction malformed
//  Revision : 1.0 - initial release
// ============================================================================
module comparator_serial_accum
    import comparator_pkg::*;
#(
    parameter int NSLICE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_first,
    input  logic in_last,
    input  logic g,
    input  logic l,
    output logic out_valid,
    input  logic out_ready,
    output logic out_g,
    output logic out_l,
    output logic out_eq,
    output logic out_err
);

    localparam int                   C_CNT_W   = $clog2(NSLICE + 1);
    localparam logic [C_CNT_W-1:0]   C_CNT_MAX = C_CNT_W'(NSLICE);
    localparam logic [C_CNT_W-1:0]   C_CNT_ONE = C_CNT_W'(1);

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    decision_t            r_dec;
    result_t              r_res;
    logic                 r_out_valid;

    logic                 w_accept;
    logic                 w_take;
    logic                 w_end;
    decision_t            w_base;
    decision_t            w_dec_next;
    logic [C_CNT_W-1:0]   w_cnt_next;
    result_t              w_res;

    // Ready is low in HOLD and while reset is asserted.
    assign in_ready   = rst_n && (r_state != HOLD);
    assign w_accept   = in_valid && in_ready;

    // A beat contributes only if it opens a transaction (from IDLE, or as
    // a restart from ACCUM) or continues an open one. An unframed beat in
    // IDLE is accepted but falls through here and is discarded.
    assign w_take     = w_accept && (in_first || (r_state == ACCUM));

    // A first-flagged beat always starts from a clean decision and count.
    assign w_base     = in_first ? C_DEC_CLEAR : r_dec;
    assign w_dec_next = slice_fold(w_base, g, l);
    assign w_cnt_next = in_first ? C_CNT_ONE : (r_cnt + C_CNT_ONE);

    // The transaction closes on in_last or on the final slice position,
    // whichever comes first.
    assign w_end      = in_last || (w_cnt_next == C_CNT_MAX);

    // Framing is good only when in_last lands exactly on the final slice.
    assign w_res.g    = w_dec_next.g;
    assign w_res.l    = w_dec_next.l;
    assign w_res.eq   = !w_dec_next.fixed;
    assign w_res.err  = w_dec_next.err || !in_last || (w_cnt_next != C_CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dec       <= C_DEC_CLEAR;
            r_res       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_take) begin
                        r_cnt <= w_cnt_next;
                        r_dec <= w_dec_next;
                        if (w_end) begin
                            r_state     <= HOLD;
                            r_res       <= w_res;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // No beat is taken in the handshake cycle; the block
                    // re-opens for input on the following cycle.
                    if (r_out_valid && out_ready) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_dec       <= C_DEC_CLEAR;
                        r_res       <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_dec       <= C_DEC_CLEAR;
                    r_res       <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_g     = r_res.g;
    assign out_l     = r_res.l;
    assign out_eq    = r_res.eq;
    assign out_err   = r_res.err;

endmodule
`default_nettype wire

// File: tb/tb_comparator_serial_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_comparator_serial_accum
//  Purpose  : Self-checking bench for comparator_serial_accum (NSLICE=4).
//             A transaction-level model collects accepted beats in a queue
//             and evaluates each closed transaction from the ordering rules;
//             a per-cycle compare process checks the DUT against it, and
//             directed vectors carry literal expected results.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_comparator_serial_accum;

    localparam int NSLICE = 4;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic in_valid  = 1'b0;
    logic in_first  = 1'b0;
    logic in_last   = 1'b0;
    logic g         = 1'b0;
    logic l         = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready;
    logic out_valid;
    logic out_g;
    logic out_l;
    logic out_eq;
    logic out_err;

    int checks = 0;
    int errors = 0;

    comparator_serial_accum #(.NSLICE(NSLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .g         (g),
        .l         (l),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_g     (out_g),
        .out_l     (out_l),
        .out_eq    (out_eq),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        bit g;
        bit l;
    } beat_t;

    beat_t      q[$];
    bit         m_started = 0;
    bit         m_hold    = 0;
    bit         m_valid   = 0;
    bit         m_open    = 0;
    bit         m_zero    = 0;
    logic [3:0] m_res     = 4'b0000;   // {g, l, eq, err}

    // The most significant slice that differs decides; contradictory slices
    // only flag an error; good framing means exactly NSLICE slices with the
    // last one marked.
    function automatic logic [3:0] evaluate(input bit last_seen);
        int dec_idx = -1;
        bit err     = !(last_seen && (q.size() == NSLICE));
        foreach (q[i]) begin
            if (q[i].g && q[i].l) err = 1;
            else if (dec_idx < 0 && (q[i].g || q[i].l)) dec_idx = i;
        end
        if (dec_idx < 0) return {1'b0, 1'b0, 1'b1, err};
        return {q[dec_idx].g, q[dec_idx].l, 1'b0, err};
    endfunction

    always @(negedge clk) begin
        if (m_started) begin
            chk("in_ready", {3'b000, in_ready}, {3'b000, rst_n && !m_hold});
            chk("out_valid", {3'b000, out_valid}, {3'b000, m_valid});
            if (m_valid || m_zero)
                chk("result", {out_g, out_l, out_eq, out_err}, m_valid ? m_res : 4'b0000);
        end
        // Advance the model with the inputs the next rising edge samples.
        if (!rst_n) begin
            m_started = 1;
            m_hold    = 0;
            m_valid   = 0;
            m_open    = 0;
            m_zero    = 1;
            q.delete();
        end else begin
            m_zero = 0;
            if (m_hold) begin
                if (out_ready) begin
                    m_hold  = 0;
                    m_valid = 0;
                end
            end else if (in_valid) begin
                if (in_first) begin
                    q.delete();
                    q.push_back('{g: g, l: l});
                    m_open = 1;
                end else if (m_open) begin
                    q.push_back('{g: g, l: l});
                end
                if (m_open && (in_last || q.size() == NSLICE)) begin
                    m_res   = evaluate(in_last);
                    m_hold  = 1;
                    m_valid = 1;
                    m_open  = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic beat(input bit f, input bit la, input bit gg, input bit ll);
        in_valid = 1'b1;
        in_first = f;
        in_last  = la;
        g        = gg;
        l        = ll;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        g        = 1'b0;
        l        = 1'b0;
    endtask

    // Result must be visible the cycle after the ending beat.
    task automatic expect_res(input string name, input logic [3:0] exp);
        @(negedge clk);
        chk({name, "_valid"}, {3'b000, out_valid}, 4'b0001);
        chk(name, {out_g, out_l, out_eq, out_err}, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {3'b000, in_ready}, 4'b0000);
        chk("reset_outputs", {out_valid, out_g, out_l, out_eq}, 4'b0000);
        chk("reset_err", {3'b000, out_err}, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {3'b000, in_ready}, 4'b0001);
        @(posedge clk);
        #1;

        // Greater decided on slice 3, later less ignored.
        beat(1, 0, 0, 0); beat(0, 0, 0, 0); beat(0, 0, 1, 0); beat(0, 1, 0, 1);
        expect_res("gt_basic", 4'b1000);

        // All-equal slices.
        beat(1, 0, 0, 0); beat(0, 0, 0, 0); beat(0, 0, 0, 0); beat(0, 1, 0, 0);
        expect_res("eq_basic", 4'b0010);

        // Short transaction: less decided, framing error.
        beat(1, 0, 0, 1); beat(0, 1, 1, 0);
        expect_res("short_lt", 4'b0101);
        // Unframed beat in IDLE is swallowed.
        beat(0, 1, 1, 0);
        repeat (3) begin
            @(negedge clk);
            chk("discard_no_valid", {3'b000, out_valid}, 4'b0000);
        end
        @(posedge clk);
        #1;

        // Backpressure: result and in_ready frozen while out_ready=0.
        out_ready = 1'b0;
        beat(1, 0, 0, 0); beat(0, 0, 0, 1); beat(0, 0, 1, 0); beat(0, 1, 0, 0);
        expect_res("bp_lt", 4'b0100);
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; g = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", {3'b000, in_ready}, 4'b0000);
            chk("bp_hold", {out_g, out_l, out_eq, out_err}, 4'b0100);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; g = 1'b0;
        @(negedge clk);
        chk("bp_release_ready", {3'b000, in_ready}, 4'b0001);
        chk("bp_release_valid", {3'b000, out_valid}, 4'b0000);
        @(posedge clk);
        #1;

        // Restart on beat 3 abandons the open transaction.
        beat(1, 0, 0, 0); beat(0, 0, 0, 0);
        beat(1, 0, 0, 1); beat(0, 0, 0, 0); beat(0, 0, 1, 0); beat(0, 1, 0, 0);
        expect_res("restart_lt", 4'b0100);

        // Reset during beat 2 drops the partial transaction.
        beat(1, 0, 1, 0);
        in_valid = 1'b1; g = 1'b0; l = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0; l = 1'b0;
        @(negedge clk);
        chk("mid_reset_ready", {3'b000, in_ready}, 4'b0001);
        chk("mid_reset_valid", {3'b000, out_valid}, 4'b0000);
        @(posedge clk);
        #1;
        beat(1, 0, 1, 1); beat(0, 0, 0, 0); beat(0, 0, 0, 0); beat(0, 1, 0, 0);
        expect_res("contra_eq", 4'b0011);

        // Single beat with first and last: complete but wrong count.
        beat(1, 1, 0, 1);
        expect_res("single_beat", 4'b0101);

        // NSLICE-th beat without in_last closes with an error.
        beat(1, 0, 0, 0); beat(0, 0, 0, 0); beat(0, 0, 0, 0); beat(0, 0, 1, 0);
        expect_res("no_last", 4'b1001);

        // Contradictory slice after a decision keeps the decision.
        beat(1, 0, 1, 0); beat(0, 0, 1, 1); beat(0, 0, 0, 1); beat(0, 1, 0, 0);
        expect_res("late_contra", 4'b1001);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comparator_serial_accum.md
COMPARATOR_SERIAL_ACCUM -- requirements
Module: comparator_serial_accum

Interface
REQ-001 Parameter NSLICE, default 8, SHALL set the number of 2-bit slices per compare transaction (8 gives 16-bit operands); legal range 1..64.
REQ-002 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  slice beat present.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 in_first  input  1  beat is the most-significant slice of a transaction.
REQ-007 in_last  input  1  beat is the least-significant slice of a transaction.
REQ-008 g  input  1  per-slice greater flag from the upstream 2-bit comparator.
REQ-009 l  input  1  per-slice less flag from the upstream 2-bit comparator.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_g, out_l, out_eq  output  1 each  wide-operand result (A>B, A<B, A==B); one-hot when out_err=0.
REQ-013 out_err  output  1  transaction malformed.

Function
REQ-014 Slices SHALL arrive MSB-first; a beat is accepted when in_valid && in_ready.
REQ-015 FSM states SHALL be IDLE, ACCUM and HOLD; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-016 IDLE: a beat with in_first=1 SHALL start a transaction, with slice count=1 and the decision taken from that beat; a beat with in_first=0 SHALL be accepted and discarded with no output.
REQ-017 Decision rule: the first accepted slice of the transaction with g=1 or l=1 SHALL fix the result; all later slices SHALL NOT change it; if every slice has g=l=0, out_eq=1.
REQ-018 A slice with g=1 and l=1 SHALL set the err flag; if no decision is fixed yet, that slice SHALL leave it unfixed.
REQ-019 ACCUM: each accepted beat SHALL increment the slice count (width clog2(NSLICE+1)).
REQ-020 An accepted beat with in_first=1 in ACCUM SHALL abandon the current transaction without output and restart from that beat.
REQ-021 The transaction SHALL end on the beat with in_last=1 or on the NSLICE-th beat, whichever comes first; a beat with both in_first and in_last set is a complete transaction.
REQ-022 On end, the FSM SHALL enter HOLD; out_err=1 if the final count != NSLICE, if in_last=0 on the NSLICE-th beat, or if REQ-018 fired.
REQ-023 Latency: out_valid SHALL assert the cycle after the ending beat is accepted.
REQ-024 The outputs SHALL remain stable while out_valid=1 && out_ready=0.
REQ-025 HOLD SHALL return to IDLE on out_valid && out_ready; no beat is accepted in that cycle, so the minimum spacing between results is 1 cycle of HOLD plus the transaction length.
REQ-026 When out_err=1, out_g, out_l and out_eq SHALL still report the accumulated decision.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, slice count 0, decision cleared, in_ready=0 during reset, and out_valid, out_g, out_l, out_eq, out_err all 0.
REQ-028 Reset mid-transaction or in HOLD SHALL drop all partial or pending results; the first cycle after release SHALL be IDLE with in_ready=1.

Structure
REQ-029 The state enum and the result struct {g,l,eq,err} SHALL live in shared package comparator_pkg.
REQ-030 No sub-module: the 2-bit slice comparator stays an external upstream instance; this block is one FSM plus a counter.

Verification (NSLICE=4)
REQ-031 Beats (g,l) = (0,0),(0,0),(1,0),(0,1) with first on beat 1 and last on beat 4 -> one cycle later out_valid=1, out_g=1, out_err=0.
REQ-032 Four beats of (0,0), properly framed -> out_eq=1, out_g=0, out_l=0, out_err=0.
REQ-033 Framed transaction with in_last on beat 2 of (0,1),(1,0) -> out_l=1, out_err=1; a subsequent unframed beat in IDLE -> discarded, no out_valid.
REQ-034 Hold out_ready=0 for 5 cycles after the result -> outputs stable and in_ready=0 throughout; after out_ready=1 for one cycle -> IDLE, in_ready=1 next cycle.
REQ-035 in_first reasserted on beat 3 of an open transaction -> the first transaction produces no output; the restarted one completes with count 4 and out_err=0.
REQ-036 rst_n=0 for one cycle during beat 2 -> no out_valid; a fresh framed (1,1),(0,0),(0,0),(0,0) -> out_err=1, out_eq=1.
